// File: rtl/bus_arb2.sv
// Purpose : two-master round-robin arbiter onto a single shared peripheral bus.
// Latency : grant on the edge after m_req in IDLE; m_ready one cycle after bus_ready (minimum 2 cycles).
// Backpressure: holds the bus until bus_ready; aborts after TIMEOUT WAIT cycles with a timeout_err pulse.
//
// Ports:
//   cpu_clk, rst_n              clock, synchronous active-low reset
//   m_req/m_we/m_re [1:0]       per-master request and direction strobes
//   m_addr/m_wdata [63:0]       master i at [32i+31:32i]
//   m_op [5:0]                  master i access code at [3i+2:3i]
//   m_ready [1:0], m_rdata      one-cycle completion pulse and read data
//   bus_*                       shared bus request side; bus_ready/bus_data_in from slaves
//   timeout_err, err_master     abort pulse and index of the last aborted master
module bus_arb2 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic [1:0]  m_req,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  input  logic [5:0]  m_op,
  input  logic [1:0]  m_we,
  input  logic [1:0]  m_re,
  output logic [1:0]  m_ready,
  output logic [31:0] m_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data_out,
  output logic [2:0]  bus_mem_op,
  output logic        bus_en,
  output logic        bus_we,
  output logic        bus_re,
  input  logic        bus_ready,
  input  logic [31:0] bus_data_in,
  output logic        timeout_err,
  output logic        err_master
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value seen during the last permitted WAIT cycle.
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t      state_q;
  logic        gnt_q;
  logic        last_grant_q;
  logic [9:0]  cnt_q;
  logic [1:0]  m_ready_q;
  logic [31:0] m_rdata_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_data_out_q;
  logic [2:0]  bus_mem_op_q;
  logic        bus_en_q;
  logic        bus_we_q;
  logic        bus_re_q;
  logic        timeout_err_q;
  logic        err_master_q;

  // Arbitration: on a tie the master not granted last time wins.
  logic        grant_d;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [2:0]  sel_op;
  logic        sel_we;
  logic        sel_re;

  always_comb begin
    grant_d = 1'b0;
    if (m_req == 2'b11) begin
      grant_d = ~last_grant_q;
    end else if (m_req[1]) begin
      grant_d = 1'b1;
    end
  end

  assign sel_addr  = grant_d ? m_addr[63:32]  : m_addr[31:0];
  assign sel_wdata = grant_d ? m_wdata[63:32] : m_wdata[31:0];
  assign sel_op    = grant_d ? m_op[5:3]      : m_op[2:0];
  assign sel_we    = grant_d ? m_we[1]        : m_we[0];
  assign sel_re    = grant_d ? m_re[1]        : m_re[0];

  // A WAIT cycle ends on bus_ready, or on the last permitted cycle; bus_ready
  // wins if both happen together.
  logic wait_end;
  assign wait_end = bus_ready || (cnt_q == CNT_LAST);

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      gnt_q          <= 1'b0;
      last_grant_q   <= 1'b1;
      cnt_q          <= '0;
      m_ready_q      <= '0;
      m_rdata_q      <= '0;
      bus_addr_q     <= '0;
      bus_data_out_q <= '0;
      bus_mem_op_q   <= '0;
      bus_en_q       <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_re_q       <= 1'b0;
      timeout_err_q  <= 1'b0;
      err_master_q   <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses.
      m_ready_q     <= '0;
      m_rdata_q     <= '0;
      timeout_err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (|m_req) begin
            gnt_q          <= grant_d;
            last_grant_q   <= grant_d;
            cnt_q          <= '0;
            bus_en_q       <= 1'b1;
            bus_addr_q     <= sel_addr;
            bus_data_out_q <= sel_wdata;
            bus_mem_op_q   <= sel_op;
            bus_we_q       <= sel_we;
            // we and re together is treated as a write
            bus_re_q       <= sel_re & ~sel_we;
            state_q        <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_end) begin
            m_ready_q[gnt_q] <= 1'b1;
            if (bus_ready) begin
              m_rdata_q <= bus_re_q ? bus_data_in : '0;
            end else begin
              timeout_err_q <= 1'b1;
              err_master_q  <= gnt_q;
            end
            bus_en_q       <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_re_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_data_out_q <= '0;
            bus_mem_op_q   <= '0;
            state_q        <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign m_ready      = m_ready_q;
  assign m_rdata      = m_rdata_q;
  assign bus_addr     = bus_addr_q;
  assign bus_data_out = bus_data_out_q;
  assign bus_mem_op   = bus_mem_op_q;
  assign bus_en       = bus_en_q;
  assign bus_we       = bus_we_q;
  assign bus_re       = bus_re_q;
  assign timeout_err  = timeout_err_q;
  assign err_master   = err_master_q;

endmodule
